branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Consumer side of the compare path: accepts a conditional-branch request (two operands,
//  3-bit condition code, branch PC, target), evaluates the condition, and returns a
//  taken/not-taken result over a valid/ready handshake. On a taken branch it issues a
//  one-cycle PC redirect and holds off new requests for a fixed refill window.
//  Sits between decode/issue and the fetch PC logic of the 16-bit CPU.
// PARAMETERS
//  DATA_W     16  operand width; compares are unsigned
//  ADDR_W     16  PC/target width
//  FLUSH_CYC   2  in_ready-low cycles after a redirect (0 = none)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       branch request valid
//  in_ready       out  1       unit can accept a request
//  in_a, in_b     in   DATA_W  operands
//  in_cond        in   3       0 eq,1 neq,2 gt,3 gte,4 lt,5 lte,6-7 reserved
//  in_pc          in   ADDR_W  PC of the branch
//  in_target      in   ADDR_W  branch target
//  res_valid      out  1       result valid
//  res_ready      in   1       result consumer ready
//  res_taken      out  1       condition true
//  res_next_pc    out  ADDR_W  taken ? target : pc+1 (mod 2^ADDR_W)
//  bad_cond       out  1       1-cycle pulse: reserved cond evaluated
//  redirect_valid out  1       1-cycle pulse: fetch must jump
//  redirect_pc    out  ADDR_W  jump address (valid with redirect_valid)
//  clr_cnt        in   1       synchronous clear of statistics counters
//  taken_cnt      out  16      taken branches, saturating at 16'hFFFF
//  ntaken_cnt     out  16      not-taken branches, saturating at 16'hFFFF
// BEHAVIOUR
//  - Reset: state IDLE; all outputs and internal registers 0. Reset mid-operation discards
//    any pending request/result; no redirect is issued.
//  - in_ready = (state==IDLE), combinational from state. Accept = in_valid & in_ready.
//  - IDLE: on accept, latch a,b,cond,pc,target -> EVAL.
//  - EVAL (1 cycle): register res_taken, res_next_pc; bad_cond pulses if cond in {6,7}
//    (reserved -> not taken). -> RESP.
//  - RESP: res_valid=1, outputs stable until res_ready. On handshake: count update; if
//    taken -> redirect_valid=1, redirect_pc=target for the next cycle and go FLUSH
//    (or IDLE when FLUSH_CYC==0, redirect still pulses); if not taken -> IDLE.
//  - FLUSH: down-counter loaded with FLUSH_CYC; in_ready=0; -> IDLE when it hits 0.
//  - Latency: accept at edge T -> res_valid high from cycle T+2. Not-taken throughput is
//    one branch per 3 cycles with res_ready held high.
//  - pc+1 wraps: in_pc=16'hFFFF not taken -> res_next_pc=16'h0000.
//  - Counters: increment on result handshake; saturate, never wrap; clr_cnt in the same
//    cycle as an increment wins (result 0).
//  - res_valid never drops without a handshake; no new accept while res_valid is high.
// STRUCTURE
//  - Shared include cond_defs.vh: condition-code localparams (COND_EQ..COND_LTE) and the
//    state encoding (IDLE, EVAL, RESP, FLUSH); decode/issue uses the same codes.
//  - Sub-module cond_eval: combinational (a,b,cond)->{taken,bad}; the rest is one FSM with
//    the flush counter and statistics counters.
// TESTING
//  1. a=5,b=5,cond=eq,pc=10,tgt=40, res_ready=1 -> res_valid at T+2, taken=1, next_pc=40,
//     redirect_pc=40 one cycle, in_ready low for 2 cycles, taken_cnt=1.
//  2. a=3,b=9,cond=gt,pc=16'hFFFF -> taken=0, next_pc=0, no redirect, ntaken_cnt=1.
//  3. res_ready=0 for 5 cycles -> res_valid/res_taken/res_next_pc stable, in_ready=0,
//     counters unchanged until handshake.
//  4. cond=6 -> bad_cond single pulse in EVAL, taken=0; cond=7 same.
//  5. taken_cnt preloaded to 16'hFFFE via 2 taken branches of 65534... (force) -> two more
//     taken -> stays 16'hFFFF; clr_cnt with handshake same cycle -> 0.
//  6. rst asserted during RESP with taken result -> next cycle res_valid=0, no
//     redirect_valid, in_ready=1; FLUSH_CYC=0 build: taken -> in_ready back high
//     the cycle after the result handshake.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared condition codes and FSM state encoding for the branch resolve path.
// Decode/issue imports the same condition codes.
package branch_resolve_unit_pkg;

    localparam logic [2:0] COND_EQ  = 3'd0;
    localparam logic [2:0] COND_NEQ = 3'd1;
    localparam logic [2:0] COND_GT  = 3'd2;
    localparam logic [2:0] COND_GTE = 3'd3;
    localparam logic [2:0] COND_LT  = 3'd4;
    localparam logic [2:0] COND_LTE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_RESP  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Unsigned condition evaluator: (a, b, cond) -> taken, plus a flag for reserved codes.
module cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        cond,
    output logic              taken,
    output logic              bad
);

    always_comb begin
        taken = 1'b0;
        bad   = 1'b0;
        case (cond)
            COND_EQ:  taken = (a == b);
            COND_NEQ: taken = (a != b);
            COND_GT:  taken = (a >  b);
            COND_GTE: taken = (a >= b);
            COND_LT:  taken = (a <  b);
            COND_LTE: taken = (a <= b);
            // Reserved codes resolve as not taken.
            default:  bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latch request, evaluate condition, hand back result,
// redirect fetch on taken branches and hold off issue for a refill window.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_cond,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_target,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_next_pc,
    output logic              bad_cond,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              clr_cnt,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       ntaken_cnt
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    // Counter holds remaining FLUSH cycles minus one, so FLUSH lasts exactly FLUSH_CYC cycles.
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        cond_q;
    logic [ADDR_W-1:0] pc_q, tgt_q;
    logic [FC_W-1:0]   flush_cnt;
    logic              ev_taken, ev_bad;
    logic              accept, hs;

    cond_eval #(.DATA_W(DATA_W)) u_eval (
        .a     (a_q),
        .b     (b_q),
        .cond  (cond_q),
        .taken (ev_taken),
        .bad   (ev_bad)
    );

    assign in_ready  = (state == S_IDLE);
    assign res_valid = (state == S_RESP);
    assign bad_cond  = (state == S_EVAL) && ev_bad;
    assign accept    = in_valid && in_ready;
    assign hs        = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_RESP;
            S_RESP:  if (res_ready) state_nxt = (res_taken && FLUSH_CYC != 0) ? S_FLUSH : S_IDLE;
            S_FLUSH: if (flush_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q            <= '0;
            b_q            <= '0;
            cond_q         <= '0;
            pc_q           <= '0;
            tgt_q          <= '0;
            res_taken      <= 1'b0;
            res_next_pc    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_cnt      <= '0;
            taken_cnt      <= '0;
            ntaken_cnt     <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                cond_q <= in_cond;
                pc_q   <= in_pc;
                tgt_q  <= in_target;
            end
            if (state == S_EVAL) begin
                res_taken   <= ev_taken;
                res_next_pc <= ev_taken ? tgt_q : pc_q + ADDR_W'(1);
            end
            if (hs && res_taken) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= tgt_q;
                flush_cnt      <= FC_LOAD;
            end else if (state == S_FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FC_W'(1);
            end
            // Clear beats a same-cycle increment; counters saturate instead of wrapping.
            if (clr_cnt) begin
                taken_cnt  <= '0;
                ntaken_cnt <= '0;
            end else if (hs) begin
                if (res_taken && taken_cnt != 16'hFFFF)
                    taken_cnt <= taken_cnt + 16'd1;
                if (!res_taken && ntaken_cnt != 16'hFFFF)
                    ntaken_cnt <= ntaken_cnt + 16'd1;
            end
        end
    end

endmodule
